// File: rtl/led_pkg.sv
// Shared encodings for the LED mode scheduler: mode codes, per-mode seed
// patterns and the number of step rates.
package led_pkg;

    localparam logic [1:0] MODE_FLOW_L   = 2'd0;
    localparam logic [1:0] MODE_FLOW_R   = 2'd1;
    localparam logic [1:0] MODE_BLINK    = 2'd2;
    localparam logic [1:0] MODE_PINGPONG = 2'd3;

    localparam logic [3:0] SEED_FLOW_L = 4'b0001;
    localparam logic [3:0] SEED_FLOW_R = 4'b1000;
    localparam logic [3:0] SEED_BLINK  = 4'b0000;
    localparam logic [3:0] SEED_PP     = 4'b0001;

    localparam int NUM_SPEEDS = 3;

    function automatic logic [3:0] seed_of(input logic [1:0] m);
        logic [3:0] s;
        case (m)
            MODE_FLOW_L: s = SEED_FLOW_L;
            MODE_FLOW_R: s = SEED_FLOW_R;
            MODE_BLINK:  s = SEED_BLINK;
            default:     s = SEED_PP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability counter,
// and a registered one-cycle pulse on each accepted press (high->low).
module key_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic          sync1_q, key_s_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (key_s_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = key_s_q;
                pulse_d  = ~key_s_q;  // only the fall to low counts as a press
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= 1'b1;
            key_s_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            key_s_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/led_mode_sched.sv
// Four-LED pattern scheduler: one button cycles the display pattern, the
// other cycles the step rate (1x/2x/4x); a tick counter paces pattern steps.
module led_mode_sched
    import led_pkg::*;
#(
    parameter int TICK_CNT = 10_000_000,
    parameter int DEB_CNT  = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    output logic [3:0] led,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TICK_CNT);

    logic          mode_pulse, speed_pulse;
    logic [TW-1:0] tick_q, tick_d, step_max;
    logic [1:0]    speed_q, speed_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    led_q, led_d;
    logic          dir_up_q, dir_up_d;
    logic          step;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_n      (key_mode),
        .press_pulse(mode_pulse)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_speed (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_n      (key_speed),
        .press_pulse(speed_pulse)
    );

    always_comb begin
        case (speed_q)
            2'd0:    step_max = TW'(TICK_CNT - 1);
            2'd1:    step_max = TW'(TICK_CNT / 2 - 1);
            default: step_max = TW'(TICK_CNT / 4 - 1);
        endcase
    end

    // Any key pulse restarts the step period so a new rate starts cleanly.
    always_comb begin
        step   = 1'b0;
        tick_d = tick_q + TW'(1);
        if (mode_pulse || speed_pulse) begin
            tick_d = '0;
        end else if (tick_q == step_max) begin
            tick_d = '0;
            step   = 1'b1;
        end
    end

    always_comb begin
        speed_d = speed_q;
        if (speed_pulse) begin
            speed_d = (speed_q == 2'(NUM_SPEEDS - 1)) ? 2'd0 : speed_q + 2'd1;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_up_d = dir_up_q;
        if (mode_pulse) begin
            mode_d   = mode_q + 2'd1;
            led_d    = seed_of(mode_q + 2'd1);
            dir_up_d = 1'b1;
        end else if (step) begin
            case (mode_q)
                MODE_FLOW_L: led_d = {led_q[2:0], led_q[3]};
                MODE_FLOW_R: led_d = {led_q[0], led_q[3:1]};
                MODE_BLINK:  led_d = ~led_q;
                default: begin
                    // Turn around at each end without repeating the end LED.
                    if (dir_up_q) begin
                        if (led_q[3]) begin
                            led_d    = 4'b0100;
                            dir_up_d = 1'b0;
                        end else begin
                            led_d = {led_q[2:0], 1'b0};
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d    = 4'b0010;
                            dir_up_d = 1'b1;
                        end else begin
                            led_d = {1'b0, led_q[3:1]};
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q   <= '0;
            speed_q  <= 2'd0;
            mode_q   <= MODE_FLOW_L;
            led_q    <= SEED_FLOW_L;
            dir_up_q <= 1'b1;
        end else begin
            tick_q   <= tick_d;
            speed_q  <= speed_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// Directed bench for led_mode_sched with TICK_CNT=8, DEB_CNT=4: a press takes
// effect 7 edges after the key falls (6 to debounce, 1 to register).
module tb_led_mode_sched;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_mode;
    logic       key_speed;
    logic [3:0] led;
    logic [1:0] mode;

    int n_checks;
    int n_pass;

    typedef struct {
        int         wait_n;
        logic [3:0] exp_led;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t flow_vecs[6];
    vec_t pp_vecs[8];

    led_mode_sched #(.TICK_CNT(8), .DEB_CNT(4)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_mode (key_mode),
        .key_speed(key_speed),
        .led      (led),
        .mode     (mode)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [3:0] exp_led,
                         input logic [1:0] exp_mode);
        n_checks++;
        if (led === exp_led && mode === exp_mode) begin
            n_pass++;
        end else begin
            $display("FAIL %s: led=%b mode=%0d, expected led=%b mode=%0d",
                     name, led, mode, exp_led, exp_mode);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        key_mode  = 1'b1;
        key_speed = 1'b1;
        sys_rst_n = 1'b0;
        wait_cyc(3);
        sys_rst_n = 1'b1;
    endtask

    // Hold the selected keys low until the resulting update has landed.
    task automatic press(input logic m, input logic s);
        key_mode  = ~m;
        key_speed = ~s;
        wait_cyc(7);
        key_mode  = 1'b1;
        key_speed = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        sys_rst_n = 1'b0;
        key_mode  = 1'b1;
        key_speed = 1'b1;

        flow_vecs[0] = '{0, 4'b0001, 2'd0};
        flow_vecs[1] = '{7, 4'b0001, 2'd0};
        flow_vecs[2] = '{1, 4'b0010, 2'd0};
        flow_vecs[3] = '{8, 4'b0100, 2'd0};
        flow_vecs[4] = '{8, 4'b1000, 2'd0};
        flow_vecs[5] = '{8, 4'b0001, 2'd0};

        pp_vecs[0] = '{0, 4'b0001, 2'd3};
        pp_vecs[1] = '{8, 4'b0010, 2'd3};
        pp_vecs[2] = '{8, 4'b0100, 2'd3};
        pp_vecs[3] = '{8, 4'b1000, 2'd3};
        pp_vecs[4] = '{8, 4'b0100, 2'd3};
        pp_vecs[5] = '{8, 4'b0010, 2'd3};
        pp_vecs[6] = '{8, 4'b0001, 2'd3};
        pp_vecs[7] = '{8, 4'b0010, 2'd3};

        // Reset state and free-running FLOW_L.
        wait_cyc(2);
        check("in_reset", 4'b0001, 2'd0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (flow_vecs[i].wait_n > 0) wait_cyc(flow_vecs[i].wait_n);
            check($sformatf("flow_l[%0d]", i), flow_vecs[i].exp_led, flow_vecs[i].exp_mode);
        end

        // Short glitch ignored, then one long press gives exactly one pulse.
        key_mode = 1'b0;
        wait_cyc(3);
        key_mode = 1'b1;
        wait_cyc(5);
        check("glitch_ignored", 4'b0010, 2'd0);
        key_mode = 1'b0;
        wait_cyc(6);
        check("press_before_update", 4'b0010, 2'd0);
        wait_cyc(1);
        check("press_mode1_seed", 4'b1000, 2'd1);
        wait_cyc(7);
        check("flow_r_hold", 4'b1000, 2'd1);
        wait_cyc(1);
        check("flow_r_step", 4'b0100, 2'd1);
        wait_cyc(25);
        check("long_hold_one_pulse", 4'b1000, 2'd1);
        key_mode = 1'b1;
        wait_cyc(10);
        check("release_no_pulse", 4'b0100, 2'd1);

        // BLINK, then PINGPONG sequence.
        do_reset();
        press(1'b1, 1'b0);
        check("mode1_seed", 4'b1000, 2'd1);
        wait_cyc(8);
        press(1'b1, 1'b0);
        check("blink_seed", 4'b0000, 2'd2);
        wait_cyc(8);
        check("blink_on", 4'b1111, 2'd2);
        wait_cyc(8);
        check("blink_off", 4'b0000, 2'd2);
        press(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (pp_vecs[i].wait_n > 0) wait_cyc(pp_vecs[i].wait_n);
            check($sformatf("pingpong[%0d]", i), pp_vecs[i].exp_led, pp_vecs[i].exp_mode);
        end

        // Reset mid-PINGPONG with key_mode held low across the release.
        key_mode = 1'b0;
        wait_cyc(3);
        sys_rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0001, 2'd0);
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(3);
        key_mode = 1'b1;
        wait_cyc(5);
        check("held_key_no_pulse", 4'b0010, 2'd0);
        wait_cyc(10);
        check("still_mode0", 4'b0100, 2'd0);
        press(1'b1, 1'b0);
        check("repress_after_reset", 4'b1000, 2'd1);

        // Speed cycling in FLOW_L: periods 8 -> 4 -> 2 -> 8.
        do_reset();
        wait_cyc(3);
        press(1'b0, 1'b1);
        check("speed1_led_kept", 4'b0010, 2'd0);
        wait_cyc(3);
        check("speed1_restart", 4'b0010, 2'd0);
        wait_cyc(1);
        check("speed1_step", 4'b0100, 2'd0);
        wait_cyc(4);
        check("speed1_step2", 4'b1000, 2'd0);
        press(1'b0, 1'b1);
        check("speed2_led_kept", 4'b0001, 2'd0);
        wait_cyc(1);
        check("speed2_hold", 4'b0001, 2'd0);
        wait_cyc(1);
        check("speed2_step", 4'b0010, 2'd0);
        wait_cyc(6);
        check("speed2_step4", 4'b0001, 2'd0);
        press(1'b0, 1'b1);
        check("speed0_led_kept", 4'b1000, 2'd0);
        wait_cyc(7);
        check("speed0_hold", 4'b1000, 2'd0);
        wait_cyc(1);
        check("speed0_step", 4'b0001, 2'd0);

        // Mode and speed pressed together.
        do_reset();
        press(1'b1, 1'b1);
        check("both_seed", 4'b1000, 2'd1);
        wait_cyc(3);
        check("both_hold", 4'b1000, 2'd1);
        wait_cyc(1);
        check("both_step_p4", 4'b0100, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
